// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states and sizing helpers.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Number of iteration cycles for a given operand width and bits per cycle.
    function automatic int div_n(input int width, input int step);
        return width / step;
    endfunction

    // Iteration counter width, clog2(N)+1.
    function automatic int cnt_w(input int width, input int step);
        return $clog2(div_n(width, step)) + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   part_rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   next_rem,
    output logic             quo_bit
);

    logic [WIDTH+1:0] trial;

    // Trial subtraction; keep the shifted remainder when the divisor does not fit.
    always_comb begin
        trial    = {part_rem, dvd_bit};
        quo_bit  = (trial >= {2'b00, divisor});
        next_rem = quo_bit ? (WIDTH+1)'(trial - {2'b00, divisor}) : (WIDTH+1)'(trial);
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle signed/unsigned integer divider, STEP quotient bits per cycle,
// result {remainder, quotient} truncated toward zero.
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Start,
    input  logic               Annul,
    output logic [2*WIDTH-1:0] Result,
    output logic               Ready,
    output logic               Busy,
    output logic               DivZero
);

    localparam int N  = div_n(WIDTH, STEP);
    localparam int CW = cnt_w(WIDTH, STEP);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state;
    state_t             state_next;
    logic               start_ok;
    logic               b_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg_a;
    logic               neg_b;
    logic               zero_flag;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dsr;
    logic [WIDTH:0]     rem;
    logic [CW-1:0]      cnt;
    logic [STEP:0][WIDTH:0] rem_chain;
    logic [STEP-1:0]    q_bits;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rmd_fix;

    // Operand magnitudes from the live inputs, and the start acceptance condition.
    always_comb begin
        b_zero   = (B == '0);
        mag_a    = (Signed && A[WIDTH-1]) ? -A : A;
        mag_b    = (Signed && B[WIDTH-1]) ? -B : B;
        start_ok = Start && !Annul && (state == IDLE || state == DONE);
    end

    // STEP restoring steps chained per cycle; dividend bits consumed MSB first.
    assign rem_chain[0] = rem;
    for (genvar i = 0; i < STEP; i++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .part_rem (rem_chain[i]),
            .dvd_bit  (dvd[WIDTH-1-i]),
            .divisor  (dsr),
            .next_rem (rem_chain[i+1]),
            .quo_bit  (q_bits[STEP-1-i])
        );
    end

    // Next-state logic; Annul overrides everything.
    always_comb begin
        state_next = state;
        if (Annul) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (Start) state_next = b_zero ? FIX : ITER;
                ITER:       if (cnt == LAST) state_next = FIX;
                FIX:        state_next = DONE;
                default:    state_next = IDLE;
            endcase
        end
    end

    // Sign fixup; a zero divisor returns all-ones quotient and the original dividend.
    always_comb begin
        quo_fix = (neg_a ^ neg_b) ? -dvd : dvd;
        rmd_fix = neg_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        if (zero_flag) begin
            quo_fix = '1;
            rmd_fix = neg_a ? -dvd : dvd;
        end
    end

    // Datapath: latch magnitudes on start, then shift quotient bits into the dividend register.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            neg_a <= Signed && A[WIDTH-1];
            neg_b <= Signed && B[WIDTH-1];
            dvd   <= mag_a;
            dsr   <= mag_b;
            rem   <= '0;
        end else if (state == ITER) begin
            rem   <= rem_chain[STEP];
            dvd   <= (dvd << STEP) | WIDTH'(q_bits);
        end
    end

    // Control and status: state, counter, flags and the registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            zero_flag <= 1'b0;
            Ready     <= 1'b0;
            Busy      <= 1'b0;
            DivZero   <= 1'b0;
            Result    <= '0;
        end else begin
            state <= state_next;
            if (Annul) begin
                Ready <= 1'b0;
                Busy  <= 1'b0;
            end else if (start_ok) begin
                cnt       <= '0;
                zero_flag <= b_zero;
                Ready     <= 1'b0;
                Busy      <= 1'b1;
            end else if (state == ITER) begin
                cnt <= cnt + CW'(1);
            end else if (state == FIX) begin
                Result  <= {rmd_fix, quo_fix};
                Ready   <= 1'b1;
                Busy    <= 1'b0;
                DivZero <= zero_flag;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: a 32-bit/STEP=1 and a 16-bit/STEP=4 instance,
// expectations from integer arithmetic, checked by per-instance monitors.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32, sgn32, start32, annul32, rdy32, busy32, dz32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rst16, sgn16, start16, annul16, rdy16, busy16, dz16;
    logic [15:0] a16, b16;
    logic [31:0] res16;

    div_iter #(.WIDTH(32), .STEP(1)) u32 (
        .clk(clk), .rst(rst32), .Signed(sgn32), .A(a32), .B(b32), .Start(start32),
        .Annul(annul32), .Result(res32), .Ready(rdy32), .Busy(busy32), .DivZero(dz32)
    );

    div_iter #(.WIDTH(16), .STEP(4)) u16 (
        .clk(clk), .rst(rst16), .Signed(sgn16), .A(a16), .B(b16), .Start(start16),
        .Annul(annul16), .Result(res16), .Ready(rdy16), .Busy(busy16), .DivZero(dz16)
    );

    typedef struct {
        logic [63:0] res;
        bit          dz;
        int          due;
    } exp_t;

    exp_t        q32[$];
    exp_t        q16[$];
    exp_t        e32, e16;
    logic [63:0] last32 = '0;
    bit          lastdz32 = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        rdy32_q = 1'b0;
    logic        rdy16_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer division, truncating toward zero.
    function automatic logic [63:0] model(input int w, input bit s, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r, mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a);
        sb = longint'(b);
        if (b == 32'd0) begin
            q = mask;
            r = sa;
        end else begin
            if (s && a[w-1]) sa = sa - (longint'(1) << w);
            if (s && b[w-1]) sb = sb - (longint'(1) << w);
            q = sa / sb;
            r = sa % sb;
        end
        return 64'(((r & mask) << w) | (q & mask));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance: compare on each rising Ready.
    always @(negedge clk) begin
        if (rdy32 && !rdy32_q) begin
            if (q32.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u32 unexpected ready: got result 0x%0h, required no output", res32);
            end else begin
                e32 = q32.pop_front();
                check("u32 result", res32, e32.res);
                check("u32 divzero", 64'(dz32), 64'(e32.dz));
                check("u32 latency", 64'(cyc), 64'(e32.due));
                last32   = e32.res;
                lastdz32 = e32.dz;
            end
        end
        rdy32_q = rdy32;
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (rdy16 && !rdy16_q) begin
            if (q16.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL u16 unexpected ready: got result 0x%0h, required no output", res16);
            end else begin
                e16 = q16.pop_front();
                check("u16 result", 64'(res16), e16.res);
                check("u16 divzero", 64'(dz16), 64'(e16.dz));
                check("u16 latency", 64'(cyc), 64'(e16.due));
            end
        end
        rdy16_q = rdy16;
    end

    // Present one request just after a falling edge; operands are scrambled after acceptance.
    task automatic issue(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] am, bm;
        am = (w == 32) ? a : {16'h0, a[15:0]};
        bm = (w == 32) ? b : {16'h0, b[15:0]};
        e.res = model(w, s, am, bm);
        e.dz  = (bm == 32'd0);
        e.due = cyc + 1 + ((bm == 32'd0) ? 1 : ((w == 32) ? 33 : 5));
        if (w == 32) begin
            sgn32 = s; a32 = am; b32 = bm; start32 = 1'b1;
            q32.push_back(e);
        end else begin
            sgn16 = s; a16 = am[15:0]; b16 = bm[15:0]; start16 = 1'b1;
            q16.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (w == 32) begin
            start32 = 1'b0; a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom);
            check("u32 busy after start", 64'(busy32), 64'd1);
            check("u32 ready after start", 64'(rdy32), 64'd0);
        end else begin
            start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sgn16 = 1'($urandom);
            check("u16 busy after start", 64'(busy16), 64'd1);
            check("u16 ready after start", 64'(rdy16), 64'd0);
        end
    endtask

    task automatic wait_ready(input int w);
        int n;
        n = 0;
        while (((w == 32) ? rdy32 : rdy16) == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (((w == 32) ? rdy32 : rdy16) == 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL u%0d timeout: ready 0 after %0d cycles, required 1", w, n);
        end
    endtask

    task automatic random_op(input int w);
        logic [31:0] a, b;
        bit          s;
        int          pick;
        a    = $urandom;
        b    = $urandom;
        s    = 1'($urandom);
        pick = $urandom_range(0, 7);
        case (pick)
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = (w == 32) ? 32'h8000_0000 : 32'h0000_8000;
            3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            default: ;
        endcase
        issue(w, s, a, b);
        wait_ready(w);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        rst32 = 1'b0; sgn32 = 1'b0; start32 = 1'b0; annul32 = 1'b0; a32 = '0; b32 = '0;
        rst16 = 1'b0; sgn16 = 1'b0; start16 = 1'b0; annul16 = 1'b0; a16 = '0; b16 = '0;
        repeat (2) @(negedge clk);
        check("u32 reset result", res32, 64'd0);
        check("u32 reset ready", 64'(rdy32), 64'd0);
        check("u32 reset busy", 64'(busy32), 64'd0);
        check("u32 reset divzero", 64'(dz32), 64'd0);
        check("u16 reset result", 64'(res16), 64'd0);
        rst32 = 1'b1;
        rst16 = 1'b1;
        @(negedge clk);

        // Directed 32-bit cases.
        issue(32, 1'b0, 32'd100, 32'd7);               wait_ready(32);
        issue(32, 1'b1, 32'hFFFF_FFF9, 32'd2);         wait_ready(32);
        issue(32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF); wait_ready(32);
        issue(32, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF); wait_ready(32);
        issue(32, 1'b0, 32'd5, 32'd0);                 wait_ready(32);
        issue(32, 1'b1, 32'd5, 32'd0);                 wait_ready(32);
        issue(32, 1'b0, 32'd9, 32'd3);                 wait_ready(32);
        issue(32, 1'b1, 32'hFFFF_FFF6, 32'd0);         wait_ready(32);
        issue(32, 1'b1, 32'd100, 32'hFFFF_FFF9);       wait_ready(32);

        // Annul mid-operation: status drops, result holds, next start accepted.
        issue(32, 1'b0, 32'd100, 32'd7);               wait_ready(32);
        issue(32, 1'b0, 32'd50, 32'd5);
        repeat (9) @(negedge clk);
        annul32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul32 = 1'b0;
        void'(q32.pop_back());
        check("u32 annul ready", 64'(rdy32), 64'd0);
        check("u32 annul busy", 64'(busy32), 64'd0);
        check("u32 annul result", res32, last32);
        check("u32 annul divzero", 64'(dz32), 64'(lastdz32));
        issue(32, 1'b0, 32'd1000, 32'd10);             wait_ready(32);

        // Annul and Start together in DONE: nothing is accepted.
        sgn32 = 1'b0; a32 = 32'd77; b32 = 32'd7; start32 = 1'b1; annul32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0; annul32 = 1'b0;
        check("u32 annul+start busy", 64'(busy32), 64'd0);
        check("u32 annul+start ready", 64'(rdy32), 64'd0);

        // Start while busy is ignored.
        issue(32, 1'b0, 32'd777777, 32'd13);
        repeat (5) @(negedge clk);
        a32 = 32'd1; b32 = 32'd1; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        wait_ready(32);

        for (int i = 0; i < 40; i++) random_op(32);

        // 16-bit / STEP=4 instance.
        issue(16, 1'b1, 32'h8001, 32'h0003);           wait_ready(16);
        issue(16, 1'b1, 32'h8000, 32'hFFFF);           wait_ready(16);
        issue(16, 1'b0, 32'h1234, 32'h0000);           wait_ready(16);

        // Asynchronous reset mid-iteration clears outputs without a clock edge.
        issue(16, 1'b0, 32'hBEEF, 32'h0011);
        @(posedge clk);
        #2;
        rst16 = 1'b0;
        #1;
        check("u16 async reset result", 64'(res16), 64'd0);
        check("u16 async reset busy", 64'(busy16), 64'd0);
        check("u16 async reset ready", 64'(rdy16), 64'd0);
        check("u16 async reset divzero", 64'(dz16), 64'd0);
        q16.delete();
        @(negedge clk);
        rst16 = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 40; i++) random_op(16);

        repeat (3) @(negedge clk);
        check("u32 pending outputs", 64'(q32.size()), 64'd0);
        check("u16 pending outputs", 64'(q16.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
